hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Parametrised hazard/forwarding controller for the 5-stage pipeline. It merges operand
//  forwarding, load-use stall, memory-wait freeze, branch flush and halt drain into one unit.
//  Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers and drives their stall/flush.
//  Generalises the old single-purpose stall logic to NRD read ports and any data/reg width.
// PARAMETERS
//  DATA_W      16  datapath width
//  REG_AW      3   register-file address width
//  NRD         2   register read ports forwarded (1..4)
//  DRAIN_CYC   3   cycles to drain EX/MEM/WB after halt reaches MEM (>=1)
//  MEM_TIMEOUT 64  max cycles mem_req may wait for mem_ack before err
// PORTS
//  clk          in  1             clock, rising edge
//  rst          in  1             one clock; reset is asynchronous and active-low
//  id_rs_addr   in  NRD*REG_AW    source reg addrs of instr in ID (port i at [i*REG_AW+:REG_AW])
//  id_rs_used   in  NRD           port i actually read by ID instr
//  ex_rs_addr   in  NRD*REG_AW    source reg addrs of instr in EX
//  ex_rs_data   in  NRD*DATA_W    register-file data latched in ID/EX
//  ex_rd_addr   in  REG_AW        EX dest reg
//  ex_reg_wr    in  1             EX instr writes reg
//  ex_mem_rd    in  1             EX instr is a load
//  br_taken_ex  in  1             branch/jump resolved taken in EX
//  mem_rd_addr  in  REG_AW        MEM dest reg
//  mem_reg_wr   in  1             MEM instr writes reg
//  mem_fwd_data in  DATA_W        ALU result in EX/MEM
//  mem_req      in  1             MEM stage load/store active
//  mem_ack      in  1             data memory completes access this cycle
//  halt_mem     in  1             HALT instr in MEM stage
//  wb_rd_addr   in  REG_AW        WB dest reg
//  wb_reg_wr    in  1             WB instr writes reg
//  wb_data      in  DATA_W        final write-back data
//  fwd_data     out NRD*DATA_W    forwarded operands to EX
//  stall_if     out 1             hold PC
//  stall_id     out 1             hold IF/ID
//  freeze       out 1             hold ID/EX, EX/MEM, MEM/WB
//  bubble_ex    out 1             load NOP into ID/EX
//  flush_ifid   out 1             load NOP into IF/ID
//  halted       out 1             pipeline halted
//  err          out 1             sticky memory timeout error
//  perf_stall   out 16            stall-cycle count (see CONFIGURATION)
//  perf_flush   out 16            flush-event count
// BEHAVIOUR
//  - Reset: FSM=RUN, pend_flush=0, wait_cnt=0, err=0, counters=0; all 1-bit outputs 0.
//  - Forwarding (comb, 0 latency) per port i: EX/MEM match (mem_reg_wr & addr eq) wins over
//    MEM/WB match (wb_reg_wr & addr eq); else ex_rs_data. Reg 0 is a real register, forwarded.
//  - Freeze (comb): mem_req & ~mem_ack -> freeze=stall_if=stall_id=1; priority over all else.
//  - wait_cnt: +1 each freeze cycle, cleared on mem_ack or ~mem_req. Reaching MEM_TIMEOUT ->
//    err=1 (sticky until reset); freeze still follows mem_ack.
//  - Load-use (comb): ex_mem_rd & ex_reg_wr & id_rs_used[i] & id_rs_addr[i]==ex_rd_addr, any i
//    -> stall_if=stall_id=bubble_ex=1 for exactly one cycle (instr then leaves EX).
//  - Branch: br_taken_ex & ~freeze -> flush_ifid=bubble_ex=1 same cycle; overrides load-use
//    (stall_if/stall_id 0). br_taken_ex during freeze sets pend_flush; applied first non-freeze
//    cycle, then cleared.
//  - FSM: RUN -> DRAIN on halt_mem & ~freeze (load cnt=DRAIN_CYC-1). DRAIN: stall_if=1,
//    flush_ifid=1, bubble_ex=1, branches ignored, cnt-- per non-freeze cycle; cnt==0 -> HALTED.
//    HALTED: halted=stall_if=stall_id=freeze=1 until reset. No other exits.
//  - Async reset mid-freeze/drain: immediate return to RUN, all outputs 0.
// CONFIGURATION
//  HAZ_PERF_EN defined: perf_stall +1 each cycle stall_if=1 in RUN; perf_flush +1 per applied
//   flush; both saturate at 16'hFFFF, cleared by reset. Not defined: both tied to 0, no regs.
// TESTING
//  1 EX/MEM r3=0x1234 and MEM/WB r3=0x5678, ex_rs_addr port0=3 -> fwd_data[15:0]=0x1234.
//  2 EX load to r2, ID reads r2 on port1 -> stall_if=stall_id=bubble_ex=1 for 1 cycle only.
//  3 mem_req=1, mem_ack after 5 cycles -> freeze=1 for 5 cycles, err=0; MEM_TIMEOUT=4 -> err=1.
//  4 br_taken_ex during freeze -> no flush until mem_ack; flush_ifid=1 next cycle, once.
//  5 halt_mem, DRAIN_CYC=3 -> DRAIN 3 cycles, halted=1 on 4th; rst low mid-drain -> RUN.
//  6 HAZ_PERF_EN: 2 load-use + 1 branch -> perf_stall=2, perf_flush=1; undefined -> both 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard / forwarding controller for the 5-stage core.
// Combines operand forwarding, load-use stall, memory-wait freeze, taken-branch
// flush and halt drain into one block that steers the pipe-register stall/flush
// controls.
// Optional feature: define HAZ_PERF_EN to build the stall/flush performance
// counters; without it perf_stall/perf_flush are tied to zero.
module hazard_ctrl #(
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 3,
  parameter int NRD         = 2,
  parameter int DRAIN_CYC   = 3,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*REG_AW-1:0] id_rs_addr,
  input  logic [NRD-1:0]        id_rs_used,
  input  logic [NRD*REG_AW-1:0] ex_rs_addr,
  input  logic [NRD*DATA_W-1:0] ex_rs_data,
  input  logic [REG_AW-1:0]     ex_rd_addr,
  input  logic                  ex_reg_wr,
  input  logic                  ex_mem_rd,
  input  logic                  br_taken_ex,
  input  logic [REG_AW-1:0]     mem_rd_addr,
  input  logic                  mem_reg_wr,
  input  logic [DATA_W-1:0]     mem_fwd_data,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  input  logic                  halt_mem,
  input  logic [REG_AW-1:0]     wb_rd_addr,
  input  logic                  wb_reg_wr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic [NRD*DATA_W-1:0] fwd_data,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  freeze,
  output logic                  bubble_ex,
  output logic                  flush_ifid,
  output logic                  halted,
  output logic                  err,
  output logic [15:0]           perf_stall,
  output logic [15:0]           perf_flush
);

  localparam int CNT_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   drain_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               pend_flush;
  logic               mem_freeze;
  logic               load_use;
  logic               flush_req;

  // The data memory has not answered yet: everything downstream must hold.
  assign mem_freeze = mem_req & ~mem_ack;
  // A taken branch, live now or remembered from a freeze, redirects fetch.
  assign flush_req  = (br_taken_ex | pend_flush) & ~mem_freeze;

  // Operand bypass per read port: youngest producer (EX/MEM) wins over MEM/WB.
  // Register 0 is a normal register here, so it is forwarded like any other.
  always_comb begin
    fwd_data = ex_rs_data;
    for (int i = 0; i < NRD; i++) begin
      if (mem_reg_wr && (ex_rs_addr[i*REG_AW +: REG_AW] == mem_rd_addr))
        fwd_data[i*DATA_W +: DATA_W] = mem_fwd_data;
      else if (wb_reg_wr && (ex_rs_addr[i*REG_AW +: REG_AW] == wb_rd_addr))
        fwd_data[i*DATA_W +: DATA_W] = wb_data;
    end
  end

  // Load-use detect: the ID instruction needs a value the EX load has not fetched.
  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if (id_rs_used[i] && (id_rs_addr[i*REG_AW +: REG_AW] == ex_rd_addr))
        load_use = 1'b1;
    end
    load_use = load_use & ex_mem_rd & ex_reg_wr;
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RUN;
    else      state <= state_nxt;
  end

  // FSM next-state: halt in MEM starts the drain, the drain ends in a dead stop.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RUN:    if (halt_mem && !mem_freeze) state_nxt = S_DRAIN;
      S_DRAIN:  if (!mem_freeze && drain_cnt == '0) state_nxt = S_HALTED;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_RUN;
    endcase
  end

  // FSM outputs: memory freeze dominates, then branch flush, then load-use.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    freeze     = 1'b0;
    bubble_ex  = 1'b0;
    flush_ifid = 1'b0;
    halted     = 1'b0;
    unique case (state)
      S_RUN: begin
        if (mem_freeze) begin
          freeze   = 1'b1;
          stall_if = 1'b1;
          stall_id = 1'b1;
        end else if (flush_req) begin
          flush_ifid = 1'b1;
          bubble_ex  = 1'b1;
        end else if (load_use) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end
      end
      S_DRAIN: begin
        if (mem_freeze) begin
          freeze   = 1'b1;
          stall_if = 1'b1;
          stall_id = 1'b1;
        end else begin
          stall_if   = 1'b1;
          flush_ifid = 1'b1;
          bubble_ex  = 1'b1;
        end
      end
      S_HALTED: begin
        halted   = 1'b1;
        stall_if = 1'b1;
        stall_id = 1'b1;
        freeze   = 1'b1;
      end
      default: ;
    endcase
  end

  // Drain countdown: loaded on halt entry, steps only on cycles the pipe advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain_cnt <= '0;
    end else if (state == S_RUN && halt_mem && !mem_freeze) begin
      drain_cnt <= CNT_W'(DRAIN_CYC - 1);
    end else if (state == S_DRAIN && !mem_freeze && drain_cnt != '0) begin
      drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // Remember a branch that resolved while frozen; apply it on the first free cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pend_flush <= 1'b0;
    else if (state != S_RUN || !mem_freeze)
      pend_flush <= 1'b0;
    else if (br_taken_ex)
      pend_flush <= 1'b1;
  end

  // Memory wait watchdog: count frozen cycles, latch a sticky error at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (!mem_freeze)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_W'(MEM_TIMEOUT))
        wait_cnt <= wait_cnt + 1'b1;
      if (mem_freeze && wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1))
        err <= 1'b1;
    end
  end

`ifdef HAZ_PERF_EN
  // Saturating counters of stalled fetch cycles and applied flushes while running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (state == S_RUN && stall_if && perf_stall != 16'hFFFF)
        perf_stall <= perf_stall + 1'b1;
      if (state == S_RUN && flush_ifid && perf_flush != 16'hFFFF)
        perf_flush <= perf_flush + 1'b1;
    end
  end
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl. Each stimulus cycle pushes
// its hand-derived expected outputs into a queue; a monitor pops one entry per
// cycle on the falling edge and compares it against the DUT.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  id_rs_addr, ex_rs_addr;
  logic [1:0]  id_rs_used;
  logic [31:0] ex_rs_data;
  logic [2:0]  ex_rd_addr, mem_rd_addr, wb_rd_addr;
  logic        ex_reg_wr, ex_mem_rd, br_taken_ex, mem_reg_wr, mem_req, mem_ack;
  logic        halt_mem, wb_reg_wr;
  logic [15:0] mem_fwd_data, wb_data;

  logic [31:0] fwd_data;
  logic        stall_if, stall_id, freeze, bubble_ex, flush_ifid, halted, err;
  logic [15:0] perf_stall, perf_flush;

  logic [31:0] t_fwd;
  logic        t_stall_if, t_stall_id, t_freeze, t_bubble_ex, t_flush_ifid, t_halted, err_to;
  logic [15:0] t_perf_stall, t_perf_flush;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .ex_rs_addr(ex_rs_addr), .ex_rs_data(ex_rs_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .br_taken_ex(br_taken_ex),
    .mem_rd_addr(mem_rd_addr), .mem_reg_wr(mem_reg_wr), .mem_fwd_data(mem_fwd_data),
    .mem_req(mem_req), .mem_ack(mem_ack), .halt_mem(halt_mem), .wb_rd_addr(wb_rd_addr),
    .wb_reg_wr(wb_reg_wr), .wb_data(wb_data), .fwd_data(fwd_data), .stall_if(stall_if),
    .stall_id(stall_id), .freeze(freeze), .bubble_ex(bubble_ex), .flush_ifid(flush_ifid),
    .halted(halted), .err(err), .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  // Short-timeout copy sharing all inputs; only its err output is checked.
  hazard_ctrl #(.MEM_TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .ex_rs_addr(ex_rs_addr), .ex_rs_data(ex_rs_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .br_taken_ex(br_taken_ex),
    .mem_rd_addr(mem_rd_addr), .mem_reg_wr(mem_reg_wr), .mem_fwd_data(mem_fwd_data),
    .mem_req(mem_req), .mem_ack(mem_ack), .halt_mem(halt_mem), .wb_rd_addr(wb_rd_addr),
    .wb_reg_wr(wb_reg_wr), .wb_data(wb_data), .fwd_data(t_fwd), .stall_if(t_stall_if),
    .stall_id(t_stall_id), .freeze(t_freeze), .bubble_ex(t_bubble_ex),
    .flush_ifid(t_flush_ifid), .halted(t_halted), .err(err_to),
    .perf_stall(t_perf_stall), .perf_flush(t_perf_flush)
  );

  // Flag vector order: {stall_if, stall_id, freeze, bubble_ex, flush_ifid, halted, err}
  localparam logic [6:0] F_NONE  = 7'b0000000;
  localparam logic [6:0] F_LDUSE = 7'b1101000;
  localparam logic [6:0] F_FLUSH = 7'b0001100;
  localparam logic [6:0] F_FRZ   = 7'b1110000;
  localparam logic [6:0] F_DRAIN = 7'b1001100;
  localparam logic [6:0] F_HALT  = 7'b1110010;
  localparam logic [31:0] RF     = 32'hBBBB_AAAA;

  typedef struct {
    string       name;
    logic [31:0] fwd;
    logic [6:0]  fl;
    logic        err_to;
    logic [15:0] ps;
    logic [15:0] pf;
    bit          use_perf;
  } exp_t;

  exp_t sb[$];

  task automatic push(input string name, input logic [31:0] fwd, input logic [6:0] fl,
                      input logic e_to, input logic [15:0] ps = 16'd0,
                      input logic [15:0] pf = 16'd0, input bit use_perf = 1'b0);
    exp_t e;
    e.name = name; e.fwd = fwd; e.fl = fl; e.err_to = e_to;
    e.ps = ps; e.pf = pf; e.use_perf = use_perf;
    sb.push_back(e);
  endtask

  // Advance one cycle and return every data input to a quiet value.
  task automatic step();
    @(posedge clk);
    #1;
    id_rs_addr = '0;  id_rs_used = '0;  ex_rs_addr = '0;  ex_rs_data = RF;
    ex_rd_addr = '0;  ex_reg_wr = 1'b0; ex_mem_rd = 1'b0; br_taken_ex = 1'b0;
    mem_rd_addr = '0; mem_reg_wr = 1'b0; mem_fwd_data = '0; mem_req = 1'b0;
    mem_ack = 1'b0;   halt_mem = 1'b0;  wb_rd_addr = '0; wb_reg_wr = 1'b0; wb_data = '0;
  endtask

  // Monitor: one comparison per pushed vector, sampled mid-cycle.
  exp_t m;
  logic [6:0] act_fl;
  bit ok;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m = sb.pop_front();
      act_fl = {stall_if, stall_id, freeze, bubble_ex, flush_ifid, halted, err};
      ok = (fwd_data === m.fwd) && (act_fl === m.fl) && (err_to === m.err_to);
`ifdef HAZ_PERF_EN
      if (m.use_perf) ok = ok && (perf_stall === m.ps) && (perf_flush === m.pf);
`else
      ok = ok && (perf_stall === 16'd0) && (perf_flush === 16'd0);
`endif
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL %s: got fwd=%h flags=%b err_to=%b ps=%0d pf=%0d, want fwd=%h flags=%b err_to=%b ps=%0d pf=%0d",
                 m.name, fwd_data, act_fl, err_to, perf_stall, perf_flush,
                 m.fwd, m.fl, m.err_to, m.ps, m.pf);
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst = 1'b0;
    step();
    push("reset", RF, F_NONE, 1'b0, 16'd0, 16'd0, 1'b1);
    step(); rst = 1'b1;

    // Forwarding: EX/MEM beats MEM/WB on the same register.
    ex_rs_addr = {3'd5, 3'd3};
    mem_rd_addr = 3'd3; mem_reg_wr = 1'b1; mem_fwd_data = 16'h1234;
    wb_rd_addr = 3'd3;  wb_reg_wr = 1'b1;  wb_data = 16'h5678;
    push("fwd_exmem_wins", 32'hBBBB_1234, F_NONE, 1'b0);

    step();
    ex_rs_addr = {3'd5, 3'd0};
    mem_rd_addr = 3'd3; mem_reg_wr = 1'b1; mem_fwd_data = 16'h1234;
    wb_rd_addr = 3'd5;  wb_reg_wr = 1'b1;  wb_data = 16'h5678;
    push("fwd_memwb_port1", 32'h5678_AAAA, F_NONE, 1'b0);

    step();
    ex_rs_addr = {3'd0, 3'd0};
    mem_rd_addr = 3'd0; mem_reg_wr = 1'b1; mem_fwd_data = 16'h0F0F;
    push("fwd_reg0", 32'h0F0F_0F0F, F_NONE, 1'b0);

    step();
    ex_rs_addr = {3'd5, 3'd3};
    mem_rd_addr = 3'd3; mem_reg_wr = 1'b0; mem_fwd_data = 16'h1234;
    wb_rd_addr = 3'd3;  wb_reg_wr = 1'b1;  wb_data = 16'h5678;
    push("fwd_mem_nowr", 32'hBBBB_5678, F_NONE, 1'b0);

    // Load-use on port 1, then the load has left EX.
    step();
    ex_mem_rd = 1'b1; ex_reg_wr = 1'b1; ex_rd_addr = 3'd2;
    id_rs_addr = {3'd2, 3'd7}; id_rs_used = 2'b10;
    push("loaduse_p1", RF, F_LDUSE, 1'b0);

    step();
    id_rs_addr = {3'd2, 3'd7}; id_rs_used = 2'b10;
    push("loaduse_released", RF, F_NONE, 1'b0);

    step();
    ex_mem_rd = 1'b1; ex_reg_wr = 1'b1; ex_rd_addr = 3'd2;
    id_rs_addr = {3'd2, 3'd7}; id_rs_used = 2'b01;
    push("loaduse_port_unused", RF, F_NONE, 1'b0);

    step();
    ex_mem_rd = 1'b1; ex_reg_wr = 1'b1; ex_rd_addr = 3'd4;
    id_rs_addr = {3'd1, 3'd4}; id_rs_used = 2'b11;
    push("loaduse_p0", RF, F_LDUSE, 1'b0);

    // Taken branch overrides a simultaneous load-use.
    step();
    br_taken_ex = 1'b1;
    ex_mem_rd = 1'b1; ex_reg_wr = 1'b1; ex_rd_addr = 3'd4;
    id_rs_addr = {3'd1, 3'd4}; id_rs_used = 2'b11;
    push("branch_over_loaduse", RF, F_FLUSH, 1'b0);

    step();
    push("perf_after_hazards", RF, F_NONE, 1'b0, 16'd2, 16'd1, 1'b1);

    // Five-cycle memory wait with a branch in the first frozen cycle.
    step();
    mem_req = 1'b1; br_taken_ex = 1'b1;
    ex_mem_rd = 1'b1; ex_reg_wr = 1'b1; ex_rd_addr = 3'd2;
    id_rs_addr = {3'd2, 3'd0}; id_rs_used = 2'b10;
    push("freeze_c1", RF, F_FRZ, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      step();
      mem_req = 1'b1;
      push($sformatf("freeze_c%0d", k), RF, F_FRZ, (k == 5));
    end

    step();
    mem_req = 1'b1; mem_ack = 1'b1;
    push("pending_flush_on_ack", RF, F_FLUSH, 1'b1);

    step();
    push("pending_flush_once", RF, F_NONE, 1'b1);

    // Halt: three drain cycles (branch ignored), then halted for good.
    step();
    halt_mem = 1'b1;
    push("halt_enter", RF, F_NONE, 1'b1);
    step();
    push("drain_1", RF, F_DRAIN, 1'b1);
    step();
    br_taken_ex = 1'b1;
    push("drain_2_branch_ignored", RF, F_DRAIN, 1'b1);
    step();
    push("drain_3", RF, F_DRAIN, 1'b1);
    step();
    push("halted_4th", RF, F_HALT, 1'b1);
    step();
    mem_req = 1'b1;
    push("halted_stays", RF, F_HALT, 1'b1);

    step();
    rst = 1'b0;
    push("reset_from_halted", RF, F_NONE, 1'b0, 16'd0, 16'd0, 1'b1);
    step(); rst = 1'b1;
    push("run_after_reset", RF, F_NONE, 1'b0);

    // Reset in the middle of a drain returns straight to RUN.
    step();
    halt_mem = 1'b1;
    push("halt_enter_2", RF, F_NONE, 1'b0);
    step();
    push("drain_1_again", RF, F_DRAIN, 1'b0);
    step();
    rst = 1'b0;
    push("reset_mid_drain", RF, F_NONE, 1'b0, 16'd0, 16'd0, 1'b1);
    step(); rst = 1'b1;
    push("run_after_drain_reset", RF, F_NONE, 1'b0);
    step();
    push("still_run", RF, F_NONE, 1'b0);

    step();
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
